// File: rtl/cfg_slv_frm_pkg.sv
`default_nettype none
// ============================================================================
// Module : cfg_slv_frm_pkg
// Brief  : Shared widths, defaults and FSM encodings for the config slave framer
// Rev    : 1.0
// ============================================================================
package cfg_slv_frm_pkg;

  localparam int BYTE_W      = 8;
  localparam int CMD_W       = 24;
  localparam int RSP_W       = 16;
  localparam int TMO_CYC_DEF = 500000;
  localparam int TMO_W_DEF   = 19;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_MID  = 2'd1,
    R_LOW  = 2'd2
  } rx_state_t;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_HIGH = 2'd1,
    T_LOW  = 2'd2
  } tx_state_t;

  // Byte of the response word presented to the UART in a given TX state
  function automatic logic [BYTE_W-1:0] rsp_byte(input logic [RSP_W-1:0] word,
                                                 input tx_state_t st);
    case (st)
      T_HIGH:  rsp_byte = word[15:8];
      T_LOW:   rsp_byte = word[7:0];
      default: rsp_byte = '0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_slv_frm_if.sv
`default_nettype none
// ============================================================================
// Module : cfg_slv_frm_if
// Brief  : UART byte side plus command-processor side of the config slave framer
// Rev    : 1.0
// ============================================================================
interface cfg_slv_frm_if;
  import cfg_slv_frm_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_rdy;
  logic              clr_rx_rdy;
  logic [BYTE_W-1:0] tx_data;
  logic              trmt;
  logic              tx_done;
  logic [CMD_W-1:0]  cmd;
  logic              cmd_rdy;
  logic              clr_cmd_rdy;
  logic [RSP_W-1:0]  resp;
  logic              snd_rsp;
  logic              rsp_busy;
  logic              frm_err;

  modport slave (
    input  rx_data, rx_rdy, tx_done, clr_cmd_rdy, resp, snd_rsp,
    output clr_rx_rdy, tx_data, trmt, cmd, cmd_rdy, rsp_busy, frm_err
  );

  modport master (
    output rx_data, rx_rdy, tx_done, clr_cmd_rdy, resp, snd_rsp,
    input  clr_rx_rdy, tx_data, trmt, cmd, cmd_rdy, rsp_busy, frm_err
  );

endinterface
`default_nettype wire

// File: rtl/cfg_tmo_cnt.sv
`default_nettype none
// ============================================================================
// Module : cfg_tmo_cnt
// Brief  : Inter-byte timeout counter; expired flags the last counted cycle
// Rev    : 1.0
// ============================================================================
module cfg_tmo_cnt #(
  parameter int TMO_CYC = 500000,
  parameter int TMO_W   = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TMO_W-1:0] c_LAST = TMO_W'(TMO_CYC - 1);

  logic [TMO_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + TMO_W'(1);
    end
  end

  assign expired = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/cfg_slv_frm.sv
`default_nettype none
// ============================================================================
// Module : cfg_slv_frm
// Brief  : Slave framer: 3-byte command assembly with timeout, 2-byte response
// Rev    : 1.0
// ============================================================================
module cfg_slv_frm
  import cfg_slv_frm_pkg::*;
#(
  parameter int TMO_CYC = TMO_CYC_DEF,
  parameter int TMO_W   = TMO_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  cfg_slv_frm_if.slave     bus
);

  // ---------------------------------------------------------------- RX side
  rx_state_t          r_rx_state;
  rx_state_t          w_rx_nxt;
  logic [15:0]        r_cmd_buf;
  logic [CMD_W-1:0]   r_cmd;
  logic               r_cmd_rdy;
  logic               r_frm_err;
  logic               w_cap_hi;
  logic               w_cap_mid;
  logic               w_done;
  logic               w_expire;
  logic               w_tmo_clr;
  logic               w_tmo_en;
  logic               w_tmo_exp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_state <= R_IDLE;
    end else begin
      r_rx_state <= w_rx_nxt;
    end
  end

  // A waiting byte always wins over an expiring timer in the same cycle
  always_comb begin
    w_rx_nxt  = r_rx_state;
    w_cap_hi  = 1'b0;
    w_cap_mid = 1'b0;
    w_done    = 1'b0;
    w_expire  = 1'b0;
    w_tmo_clr = 1'b1;
    w_tmo_en  = 1'b0;
    case (r_rx_state)
      R_IDLE: begin
        if (bus.rx_rdy) begin
          w_cap_hi = 1'b1;
          w_rx_nxt = R_MID;
        end
      end
      R_MID: begin
        if (bus.rx_rdy) begin
          w_cap_mid = 1'b1;
          w_rx_nxt  = R_LOW;
        end else begin
          w_tmo_clr = w_tmo_exp;
          w_tmo_en  = 1'b1;
          if (w_tmo_exp) begin
            w_expire = 1'b1;
            w_rx_nxt = R_IDLE;
          end
        end
      end
      R_LOW: begin
        if (bus.rx_rdy) begin
          w_done   = 1'b1;
          w_rx_nxt = R_IDLE;
        end else begin
          w_tmo_clr = w_tmo_exp;
          w_tmo_en  = 1'b1;
          if (w_tmo_exp) begin
            w_expire = 1'b1;
            w_rx_nxt = R_IDLE;
          end
        end
      end
      default: begin
        w_rx_nxt = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cmd_buf <= '0;
      r_cmd     <= '0;
      r_cmd_rdy <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      if (w_cap_hi) begin
        r_cmd_buf[15:8] <= bus.rx_data;
      end
      if (w_cap_mid) begin
        r_cmd_buf[7:0] <= bus.rx_data;
      end
      if (w_done) begin
        r_cmd     <= {r_cmd_buf, bus.rx_data};
        r_cmd_rdy <= 1'b1;
      end else if (bus.clr_cmd_rdy) begin
        r_cmd_rdy <= 1'b0;
      end
      r_frm_err <= w_expire;
    end
  end

  cfg_tmo_cnt #(
    .TMO_CYC (TMO_CYC),
    .TMO_W   (TMO_W)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_tmo_clr),
    .en      (w_tmo_en),
    .expired (w_tmo_exp)
  );

  assign bus.clr_rx_rdy = rst_n & (w_cap_hi | w_cap_mid | w_done);
  assign bus.cmd        = r_cmd;
  assign bus.cmd_rdy    = r_cmd_rdy;
  assign bus.frm_err    = r_frm_err;

  // ---------------------------------------------------------------- TX side
  tx_state_t          r_tx_state;
  tx_state_t          w_tx_nxt;
  logic [RSP_W-1:0]   r_rsp_buf;
  logic               r_trmt;
  logic               w_trmt_nxt;
  logic               w_load;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_state <= T_IDLE;
      r_trmt     <= 1'b0;
    end else begin
      r_tx_state <= w_tx_nxt;
      r_trmt     <= w_trmt_nxt;
    end
  end

  // tx_done coinciding with trmt belongs to the previous byte and is dropped
  always_comb begin
    w_tx_nxt   = r_tx_state;
    w_trmt_nxt = 1'b0;
    w_load     = 1'b0;
    case (r_tx_state)
      T_IDLE: begin
        if (bus.snd_rsp) begin
          w_load     = 1'b1;
          w_trmt_nxt = 1'b1;
          w_tx_nxt   = T_HIGH;
        end
      end
      T_HIGH: begin
        if (bus.tx_done && !r_trmt) begin
          w_trmt_nxt = 1'b1;
          w_tx_nxt   = T_LOW;
        end
      end
      T_LOW: begin
        if (bus.tx_done && !r_trmt) begin
          w_tx_nxt = T_IDLE;
        end
      end
      default: begin
        w_tx_nxt = T_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_buf <= '0;
    end else if (w_load) begin
      r_rsp_buf <= bus.resp;
    end
  end

  assign bus.tx_data  = rsp_byte(r_rsp_buf, r_tx_state);
  assign bus.trmt     = r_trmt;
  assign bus.rsp_busy = (r_tx_state != T_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cfg_slv_frm.sv
`default_nettype none
// ============================================================================
// Module : tb_cfg_slv_frm
// Brief  : Scoreboard bench for cfg_slv_frm with a short timeout (64 cycles)
// Rev    : 1.0
// ============================================================================
module tb_cfg_slv_frm;
  import cfg_slv_frm_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic done_model = 1'b0;
  logic done_man = 1'b0;
  logic auto_done = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_clr = 0;

  logic [23:0] cmd_q[$];
  logic [7:0]  tx_q[$];
  int          err_q[$];
  logic [23:0] prev_cmd = '0;
  logic        prev_rdy = 1'b0;

  cfg_slv_frm_if bus ();

  assign bus.tx_done = done_model | done_man;

  cfg_slv_frm #(.TMO_CYC(64), .TMO_W(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected items whenever the DUT presents an output event
  always @(negedge clk) begin
    if (bus.clr_rx_rdy) n_clr++;
    if (bus.trmt) begin
      if (tx_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL tx_unexpected: got trmt with tx_data %h, required no trmt", bus.tx_data);
      end else begin
        chk("tx_byte", 32'(bus.tx_data), 32'(tx_q.pop_front()));
      end
    end
    if (bus.frm_err) begin
      if (err_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL frm_err_unexpected: got frm_err at cycle %0d, required none", cyc);
      end else begin
        chk("frm_err_cycle", 32'(cyc), 32'(err_q.pop_front()));
      end
    end
    if (rst_n && bus.cmd_rdy && (bus.cmd != prev_cmd || !prev_rdy)) begin
      if (cmd_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL cmd_unexpected: got cmd %h, required no new frame", bus.cmd);
      end else begin
        chk("cmd_frame", 32'(bus.cmd), 32'(cmd_q.pop_front()));
      end
    end
    prev_cmd = bus.cmd;
    prev_rdy = bus.cmd_rdy;
  end

  // UART transmitter model: tx_done arrives 20 cycles after each trmt
  initial begin
    forever begin
      @(negedge clk);
      if (bus.trmt && auto_done) begin
        repeat (19) @(posedge clk);
        #1 done_model = 1'b1;
        @(posedge clk);
        #1 done_model = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_rdy  = 1'b0;
  endtask

  task automatic pulse_snd(input logic [15:0] r);
    bus.resp    = r;
    bus.snd_rsp = 1'b1;
    @(posedge clk);
    #1;
    bus.snd_rsp = 1'b0;
  endtask

  task automatic wait_not_busy(input int start, input string name);
    for (int i = 0; i < 200 && bus.rsp_busy; i++) begin
      @(posedge clk);
      #1;
    end
    chk({name, "_busy_len"}, 32'(cyc - start), 32'd40);
  endtask

  task automatic manual_done();
    done_man = 1'b1;
    @(posedge clk);
    #1;
    done_man = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cmd"},      32'(bus.cmd),      32'h0);
    chk({tag, "_cmd_rdy"},  32'(bus.cmd_rdy),  32'h0);
    chk({tag, "_tx_data"},  32'(bus.tx_data),  32'h0);
    chk({tag, "_trmt"},     32'(bus.trmt),     32'h0);
    chk({tag, "_rsp_busy"}, 32'(bus.rsp_busy), 32'h0);
    chk({tag, "_frm_err"},  32'(bus.frm_err),  32'h0);
  endtask

  initial begin
    int s;
    int c0;
    bus.rx_data = '0; bus.rx_rdy = 1'b0; bus.clr_cmd_rdy = 1'b0;
    bus.resp = '0; bus.snd_rsp = 1'b0;

    idle(3);
    chk_zero("rst");
    chk("rst_clr_rx_rdy", 32'(bus.clr_rx_rdy), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // 1: basic frame, 10-cycle gaps
    c0 = n_clr;
    cmd_q.push_back(24'hA53C0F);
    send_byte(8'hA5); idle(10);
    send_byte(8'h3C); idle(10);
    chk("t1_rdy_before", 32'(bus.cmd_rdy), 32'h0);
    send_byte(8'h0F);
    chk("t1_cmd_rdy", 32'(bus.cmd_rdy), 32'h1);
    chk("t1_cmd", 32'(bus.cmd), 32'hA53C0F);
    idle(2);
    chk("t1_clr_count", 32'(n_clr - c0), 32'd3);

    // 2: completion coincident with clr_cmd_rdy
    cmd_q.push_back(24'h112233);
    send_byte(8'h11); idle(10);
    send_byte(8'h22); idle(10);
    bus.clr_cmd_rdy = 1'b1;
    send_byte(8'h33);
    bus.clr_cmd_rdy = 1'b0;
    chk("t2_cmd_rdy", 32'(bus.cmd_rdy), 32'h1);
    idle(2);
    bus.clr_cmd_rdy = 1'b1; idle(1); bus.clr_cmd_rdy = 1'b0;
    chk("t2_cleared", 32'(bus.cmd_rdy), 32'h0);

    // 3: partial frame times out
    send_byte(8'hAA); idle(10);
    send_byte(8'hBB);
    err_q.push_back(cyc + 64);
    idle(64); idle(3);
    chk("t3_cmd_kept", 32'(bus.cmd), 32'h112233);
    chk("t3_rdy_kept", 32'(bus.cmd_rdy), 32'h0);
    cmd_q.push_back(24'h010203);
    send_byte(8'h01); idle(4);
    send_byte(8'h02); idle(4);
    send_byte(8'h03); idle(2);

    // 3b: byte arriving in the expiry cycle is accepted
    cmd_q.push_back(24'h445566);
    send_byte(8'h44); idle(63);
    send_byte(8'h55); idle(63);
    send_byte(8'h66); idle(3);
    chk("t3b_cmd", 32'(bus.cmd), 32'h445566);

    // 4: response BEEF
    tx_q.push_back(8'hBE); tx_q.push_back(8'hEF);
    pulse_snd(16'hBEEF);
    s = cyc;
    chk("t4_busy_start", 32'(bus.rsp_busy), 32'h1);
    wait_not_busy(s, "t4");
    chk("t4_idle_tx_data", 32'(bus.tx_data), 32'h0);
    idle(5);

    // 5: snd_rsp while busy is ignored
    tx_q.push_back(8'hBE); tx_q.push_back(8'hEF);
    pulse_snd(16'hBEEF);
    s = cyc;
    idle(5);
    pulse_snd(16'h1234);
    idle(20);
    pulse_snd(16'h1234);
    wait_not_busy(s, "t5");
    idle(30);

    // 7: tx_done during a trmt cycle is ignored
    auto_done = 1'b0;
    tx_q.push_back(8'hCA); tx_q.push_back(8'hFE);
    pulse_snd(16'hCAFE);
    manual_done();
    chk("t7_hold_hi_data", 32'(bus.tx_data), 32'hCA);
    chk("t7_hold_busy", 32'(bus.rsp_busy), 32'h1);
    idle(3);
    manual_done();
    manual_done();
    chk("t7_hold_lo_data", 32'(bus.tx_data), 32'hFE);
    idle(2);
    manual_done();
    chk("t7_done_busy", 32'(bus.rsp_busy), 32'h0);
    auto_done = 1'b1;
    idle(3);

    // 6: reset mid-frame and mid-response
    tx_q.push_back(8'h13);
    pulse_snd(16'h1357);
    idle(3);
    send_byte(8'h77); idle(2);
    send_byte(8'h88); idle(1);
    rst_n = 1'b0;
    bus.rx_data = 8'h99; bus.rx_rdy = 1'b1;
    #1 chk("t6_clr_in_rst", 32'(bus.clr_rx_rdy), 32'h0);
    @(posedge clk); #1;
    bus.rx_rdy = 1'b0;
    chk_zero("t6");
    rst_n = 1'b1;
    idle(80);
    cmd_q.push_back(24'h9ABCDE);
    send_byte(8'h9A); idle(3);
    send_byte(8'hBC); idle(3);
    send_byte(8'hDE); idle(3);
    chk("t6_cmd", 32'(bus.cmd), 32'h9ABCDE);
    idle(5);

    chk("cmd_q_left", 32'(cmd_q.size()), 32'h0);
    chk("tx_q_left",  32'(tx_q.size()),  32'h0);
    chk("err_q_left", 32'(err_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
